debug_display_scanner: RTL and testbench
========================================

Name: debug_display_scanner

Overview:
- Parametrised successor to the fixed 4-digit, 2-source, top/bottom-half debug display path.
- Selects one of NCH debug words and splits it into pages of DIGITS hex nibbles.
- Steps pages with a debounced push button, time-multiplexes the digits onto one active-low 7-segment bus, and hex-decodes internally.
- Sits between the processor debug taps (register value, instruction, PC, ...) and the board display pins.

Parameters:
- DIGITS, 4: number of 7-seg digits; 1..8.
- WORD_W, 32: width of each debug word; must be a multiple of 4*DIGITS.
- NCH, 2: number of debug source channels; >=1.
- REFRESH_DIV, 100000: clk cycles each digit is driven; >=2.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles needed to accept a button level; >=2.
- PAGES (derived, local): WORD_W/(4*DIGITS). Defaults give 2.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- ch_data, input, NCH*WORD_W: channel c occupies bits [c*WORD_W +: WORD_W].
- ch_sel, input, max(1,clog2(NCH)): selected channel. Values >= NCH select channel 0.
- page_btn, input, 1: raw, asynchronous, bouncing push button, active-high.
- blank_mask, input, DIGITS: bit d=1 forces digit d dark.
- seg_n, output, 7: segments, active-low. Bit 6 = a through bit 0 = g.
- dp_n, output, 1: decimal point, active-low.
- anode_n, output, DIGITS: digit enables, active-low, one-hot-low. Bit 0 = rightmost digit.
- page_idx, output, max(1,clog2(PAGES)): current page.

Behaviour:
- Reset (async, active-high): all state is cleared immediately.
  - Refresh counter, digit index, page_idx, debounce counter, both sync flops, debounced level and ch_sel shadow go to 0.
  - anode_n becomes all 1s, seg_n 7'h7F, dp_n 1.
- Button path:
  - page_btn passes through a 2-flop synchroniser.
  - When the synchronised value differs from the debounced level, a counter increments. It restarts at 0 whenever the two are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronised value and the counter clears.
  - A 0->1 transition of the debounced level is a press pulse (1 cycle).
- Page control:
  - A press pulse does page_idx <= (page_idx==PAGES-1) ? 0 : page_idx+1.
  - With PAGES==1, page_idx stays 0.
  - A registered shadow of ch_sel is kept. When ch_sel differs from the shadow, page_idx <= 0 and the shadow updates.
  - If a channel change and a press pulse occur in the same cycle, the channel change wins and page_idx goes to 0.
- Scan:
  - The refresh counter runs 0..REFRESH_DIV-1 and wraps.
  - On the wrap cycle the digit index advances; DIGITS-1 wraps to 0.
- Digit data:
  - Digit d on page p shows word[(p*DIGITS+d)*4 +: 4] of the selected channel.
  - Page 0, digit 0 is the least-significant nibble.
- Output registers (all outputs are registered, updated every clk):
  - anode_n: bit[digit index] = 0 and all other bits 1. If blank_mask[digit index] = 1, anode_n is all 1s.
  - seg_n: hex decode of the current nibble. ch_data is sampled live with no capture, so changes show on the next update.
  - dp_n: 0 when digit index == DIGITS-1 and page_idx != 0, i.e. leftmost dot means "not page 0"; otherwise 1.
  - Latency: outputs reflect digit index, page and data 1 cycle after they change.
- Hex decode, seg_n values for 0..F:
  - 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111,
  - 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
- A reset mid-scan or mid-debounce aborts the operation. There is no residual press after reset release, even if page_btn is held; the press registers only once the debounce counter completes from 0.

Test Plan:
- Bench parameters: DIGITS=4, WORD_W=32, NCH=2, REFRESH_DIV=4, DEBOUNCE_CYCLES=8 unless noted.
- Reset: assert reset mid-cycle -> anode_n=4'hF, seg_n=7'h7F, dp_n=1, page_idx=0 immediately; after release, anode_n=4'b1110 within 1 clk.
- Scan: ch0=32'h1234ABCD, ch_sel=0 -> anode_n steps 1110/1101/1011/0111 every 4 clks. seg_n shows D,C,B,A = 1000010, 0110001, 1100000, 0001000. dp_n stays 1.
- Page: hold page_btn high 12 clks -> exactly one increment, page_idx=1. Digits show 4,3,2,1; dp_n=0 only while anode_n=0111. A second clean press returns page_idx to 0.
- Debounce: toggle page_btn every 3 clks for 40 clks, then leave it low -> page_idx unchanged.
- Channel: page_idx=1, change ch_sel to 1 with ch1=32'h00000F00 -> page_idx=0 within 2 clks; digit 2 shows F (0111000). Press and channel change in the same cycle -> page_idx=0.
- Blank/params: blank_mask=4'b0100 -> anode_n is 4'hF during the digit-2 slot. Rerun with DIGITS=8, NCH=3, ch_sel=3 -> 8-slot scan, channel 0 shown, PAGES=1, page_idx stays 0 on presses.

Source files
------------

// File: rtl/debug_display_scanner.sv
// Debug word pager: picks one of NCH debug words, steps through DIGITS-nibble pages with a
// debounced button, and scans the selected page onto an active-low multiplexed 7-seg display.
module debug_display_scanner #(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned WORD_W          = 32,
  parameter int unsigned NCH             = 2,
  parameter int unsigned REFRESH_DIV     = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  localparam int unsigned PAGES = WORD_W / (4 * DIGITS),
  localparam int unsigned SEL_W = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned PG_W  = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH*WORD_W-1:0] ch_data,
  input  logic [SEL_W-1:0]      ch_sel,
  input  logic                  page_btn,
  input  logic [DIGITS-1:0]     blank_mask,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     anode_n,
  output logic [PG_W-1:0]       page_idx
);

  localparam int unsigned DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned REF_W = $clog2(REFRESH_DIV);
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES);

  logic             btn_s1_q, btn_s2_q;
  logic             btn_lvl_q, btn_lvl_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             press;
  logic [SEL_W-1:0] sel_shadow_q;
  logic [PG_W-1:0]  page_d;
  logic [REF_W-1:0] ref_cnt_q;
  logic [DIG_W-1:0] digit_q;
  logic             wrap;
  logic [31:0]      sel_ext, ch_idx, nib_pos;
  logic [WORD_W-1:0] word;
  logic [3:0]       nibble;
  logic [DIGITS-1:0] anode_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  // Level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    btn_lvl_d = btn_lvl_q;
    deb_cnt_d = '0;
    press     = 1'b0;
    if (btn_s2_q != btn_lvl_q) begin
      if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_lvl_d = btn_s2_q;
        press     = btn_s2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // A channel change takes priority over a simultaneous press.
  always_comb begin
    page_d = page_idx;
    if (ch_sel != sel_shadow_q) begin
      page_d = '0;
    end else if (press) begin
      page_d = (page_idx == PG_W'(PAGES - 1)) ? '0 : page_idx + PG_W'(1);
    end
  end

  assign wrap = (ref_cnt_q == REF_W'(REFRESH_DIV - 1));

  always_comb begin
    sel_ext = 32'(ch_sel);
    ch_idx  = (sel_ext >= NCH) ? 32'd0 : sel_ext;
    word    = WORD_W'(ch_data >> (ch_idx * WORD_W));
    nib_pos = 32'(page_idx) * DIGITS + 32'(digit_q);
    nibble  = 4'(word >> (nib_pos * 4));
    anode_d = '1;
    if (!blank_mask[digit_q]) begin
      anode_d[digit_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1_q     <= 1'b0;
      btn_s2_q     <= 1'b0;
      btn_lvl_q    <= 1'b0;
      deb_cnt_q    <= '0;
      sel_shadow_q <= '0;
      page_idx     <= '0;
      ref_cnt_q    <= '0;
      digit_q      <= '0;
      anode_n      <= '1;
      seg_n        <= 7'h7F;
      dp_n         <= 1'b1;
    end else begin
      btn_s1_q     <= page_btn;
      btn_s2_q     <= btn_s1_q;
      btn_lvl_q    <= btn_lvl_d;
      deb_cnt_q    <= deb_cnt_d;
      sel_shadow_q <= ch_sel;
      page_idx     <= page_d;
      ref_cnt_q    <= wrap ? '0 : ref_cnt_q + REF_W'(1);
      if (wrap) begin
        digit_q <= (digit_q == DIG_W'(DIGITS - 1)) ? '0 : digit_q + DIG_W'(1);
      end
      anode_n <= anode_d;
      seg_n   <= hex7(nibble);
      dp_n    <= !((digit_q == DIG_W'(DIGITS - 1)) && (page_idx != '0));
    end
  end

endmodule

// File: tb/tb_debug_display_scanner.sv
// Bench for debug_display_scanner: a 4-digit/2-channel instance and an 8-digit/3-channel
// instance checked every cycle against a behavioural model, plus literal spot checks.
module tb_debug_display_scanner;
  localparam int R = 4;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic page_btn = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] ch_data_a;
  logic [0:0]  ch_sel_a;
  logic [3:0]  blank_a;
  logic [6:0]  seg_a;
  logic        dp_a;
  logic [3:0]  anode_a;
  logic [0:0]  page_a;

  logic [95:0] ch_data_b;
  logic [1:0]  ch_sel_b;
  logic [7:0]  blank_b;
  logic [6:0]  seg_b;
  logic        dp_b;
  logic [7:0]  anode_b;
  logic [0:0]  page_b;

  debug_display_scanner #(
    .DIGITS(4), .WORD_W(32), .NCH(2), .REFRESH_DIV(R), .DEBOUNCE_CYCLES(DB)
  ) dut_a (
    .clk(clk), .reset(reset), .ch_data(ch_data_a), .ch_sel(ch_sel_a), .page_btn(page_btn),
    .blank_mask(blank_a), .seg_n(seg_a), .dp_n(dp_a), .anode_n(anode_a), .page_idx(page_a)
  );

  debug_display_scanner #(
    .DIGITS(8), .WORD_W(32), .NCH(3), .REFRESH_DIV(R), .DEBOUNCE_CYCLES(DB)
  ) dut_b (
    .clk(clk), .reset(reset), .ch_data(ch_data_b), .ch_sel(ch_sel_b), .page_btn(page_btn),
    .blank_mask(blank_b), .seg_n(seg_b), .dp_n(dp_b), .anode_n(anode_b), .page_idx(page_b)
  );

  int n_tests = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: configuration and live inputs per instance
  int n_dig [2] = '{4, 8};
  int n_ch  [2] = '{2, 3};
  int n_pg  [2] = '{2, 1};
  logic [6:0] hex_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic [95:0] m_data [2];
  int          m_sel  [2];
  logic [7:0]  m_blank [2];
  assign m_data[0]  = {32'h0, ch_data_a};
  assign m_data[1]  = ch_data_b;
  assign m_sel[0]   = int'(ch_sel_a);
  assign m_sel[1]   = int'(ch_sel_b);
  assign m_blank[0] = {4'h0, blank_a};
  assign m_blank[1] = blank_b;

  int         cyc;
  bit         level;
  bit         raw_q [$];
  bit         win [$];
  int         page [2];
  int         shadow [2];
  logic [7:0] e_anode [2];
  logic [6:0] e_seg [2];
  logic       e_dp [2];

  always @(posedge clk or posedge reset) begin : model
    bit s2, press, all_diff;
    int dig, sel;
    logic [95:0] w;
    if (reset) begin
      cyc = 0;
      level = 1'b0;
      raw_q.delete();
      win.delete();
      for (int k = 0; k < 2; k++) begin
        page[k] = 0;
        shadow[k] = 0;
        e_anode[k] = 8'hFF;
        e_seg[k] = 7'h7F;
        e_dp[k] = 1'b1;
      end
    end else begin
      // synchronised button seen at this edge is the raw sample from two edges earlier
      s2 = (raw_q.size() >= 2) ? raw_q[raw_q.size() - 2] : 1'b0;
      raw_q.push_back(page_btn);
      if (raw_q.size() > 2) void'(raw_q.pop_front());
      win.push_back(s2);
      if (win.size() > DB) void'(win.pop_front());
      all_diff = (win.size() == DB);
      foreach (win[i]) if (win[i] == level) all_diff = 1'b0;
      press = 1'b0;
      if (all_diff) begin
        press = !level;
        level = !level;
        win.delete();
      end
      for (int k = 0; k < 2; k++) begin
        dig = (cyc / R) % n_dig[k];
        sel = (m_sel[k] >= n_ch[k]) ? 0 : m_sel[k];
        w = m_data[k] >> (sel * 32 + (page[k] * n_dig[k] + dig) * 4);
        e_anode[k] = m_blank[k][dig] ? 8'hFF : ~(8'h01 << dig);
        e_seg[k] = hex_tab[w[3:0]];
        e_dp[k] = !(dig == n_dig[k] - 1 && page[k] != 0);
        if (m_sel[k] != shadow[k]) begin
          page[k] = 0;
          shadow[k] = m_sel[k];
        end else if (press) begin
          page[k] = (page[k] + 1) % n_pg[k];
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_anode", {24'h0, 4'hF, anode_a}, {24'h0, e_anode[0]});
      check("a_seg", 32'(seg_a), 32'(e_seg[0]));
      check("a_dp", 32'(dp_a), 32'(e_dp[0]));
      check("a_page", 32'(page_a), 32'(page[0]));
      check("b_anode", 32'(anode_b), {24'h0, e_anode[1]});
      check("b_seg", 32'(seg_b), 32'(e_seg[1]));
      check("b_dp", 32'(dp_b), 32'(e_dp[1]));
      check("b_page", 32'(page_b), 32'(page[1]));
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_anode(input bit use_b, input logic [7:0] v, input string name);
    int i;
    logic [7:0] cur;
    i = 0;
    cur = use_b ? anode_b : {4'hF, anode_a};
    while (cur !== v && i < 60) begin
      @(negedge clk);
      i++;
      cur = use_b ? anode_b : {4'hF, anode_a};
    end
    if (cur !== v) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout, anode_n %b, expected %b", name, cur, v);
    end
  endtask

  task automatic press_btn();
    page_btn = 1'b1;
    clks(12);
    page_btn = 1'b0;
    clks(14);
  endtask

  logic [3:0] scan_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] scan_sg [4] = '{7'b1000010, 7'b0110001, 7'b1100000, 7'b0001000};

  initial begin
    ch_data_a = {32'h00000F00, 32'h1234ABCD};
    ch_sel_a  = 1'b0;
    blank_a   = 4'h0;
    ch_data_b = {32'hDEADBEEF, 32'h0BADF00D, 32'h87654321};
    ch_sel_b  = 2'd3;
    blank_b   = 8'h00;
    #2 reset = 1'b1;
    #1 chk_en = 1'b1;
    clks(3);
    reset = 1'b0;

    // scan of page 0, channel 0
    for (int s = 0; s < 4; s++) begin
      clks((s == 0) ? 1 : R);
      check("scan_anode", 32'(anode_a), 32'(scan_an[s]));
      check("scan_seg", 32'(seg_a), 32'(scan_sg[s]));
      check("scan_dp", 32'(dp_a), 32'd1);
    end

    // one long press -> page 1; leftmost digit shows 1 with the dot lit
    press_btn();
    check("press_page1", 32'(page_a), 32'd1);
    check("b_page_stuck", 32'(page_b), 32'd0);
    wait_anode(1'b0, 8'hF7, "wait_d3");
    check("page1_d3_seg", 32'(seg_a), 32'(7'b1001111));
    check("page1_d3_dp", 32'(dp_a), 32'd0);
    press_btn();
    check("press_wrap", 32'(page_a), 32'd0);

    // bouncing input never settles long enough
    for (int i = 0; i < 13; i++) begin
      page_btn = ~page_btn;
      clks(3);
    end
    page_btn = 1'b0;
    clks(14);
    check("bounce_page", 32'(page_a), 32'd0);

    // channel change resets the page
    press_btn();
    check("pre_chan_page", 32'(page_a), 32'd1);
    ch_sel_a = 1'b1;
    clks(2);
    check("chan_page", 32'(page_a), 32'd0);
    wait_anode(1'b0, 8'hFB, "wait_d2");
    check("chan_d2_seg", 32'(seg_a), 32'(7'b0111000));

    // press pulse lands on the 10th edge after the rising edge; change channel on that edge
    page_btn = 1'b1;
    clks(9);
    ch_sel_a = 1'b0;
    clks(1);
    check("chan_beats_press", 32'(page_a), 32'd0);
    page_btn = 1'b0;
    clks(14);

    // blanked digit 2
    blank_a = 4'b0100;
    wait_anode(1'b0, 8'hFE, "wait_d0");
    wait_anode(1'b0, 8'hFD, "wait_d1");
    clks(R);
    check("blank_d2", 32'(anode_a), 32'hF);
    blank_a = 4'h0;

    // 8-digit instance: out-of-range select shows channel 0
    wait_anode(1'b1, 8'h7F, "wait_b_d7");
    check("b_d7_seg", 32'(seg_b), 32'(7'b0000000));
    check("b_d7_dp", 32'(dp_b), 32'd1);

    // reset in the middle of a cycle clears everything at once
    press_btn();
    check("pre_reset_page", 32'(page_a), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_anode", 32'(anode_a), 32'hF);
    check("rst_seg", 32'(seg_a), 32'h7F);
    check("rst_dp", 32'(dp_a), 32'd1);
    check("rst_page", 32'(page_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    clks(1);
    check("post_rst_anode", 32'(anode_a), 32'(4'b1110));
    clks(20);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
